// File: rtl/lv_adc_pkg.sv
// Shared types and helpers for the LV ADC readout scheduler.
package lv_adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        GAP
    } lv_adc_st_e;

    // Next set mask bit strictly after ptr, wrapping modulo n (n <= 16).
    function automatic int unsigned rr_next(input logic [15:0] mask, input int unsigned ptr,
                                            input int unsigned n);
        logic [3:0] cand;
        logic       found;
        int unsigned idx;
        idx   = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= 16; i++) begin
            cand = 4'((ptr + i) % n);
            if (!found && (i <= n) && mask[cand]) begin
                idx   = 32'(cand);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lv_adc_ch_reg.sv
// Per-channel result register with valid pulse.
// LV_ADC_AVG_EN: rounded running average after the first sample.
module lv_adc_ch_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
`ifdef LV_ADC_AVG_EN
    input  logic              i_mask,
`endif
    output logic [DATA_W-1:0] o_data,
    output logic              o_vld
);

    logic [DATA_W-1:0] r_data;
    logic              r_vld;
    logic [DATA_W-1:0] w_data_d;

`ifdef LV_ADC_AVG_EN
    logic            r_seen;
    logic [DATA_W:0] w_sum;

    always_comb begin
        w_sum    = {1'b0, r_data} + {1'b0, i_data} + {{DATA_W{1'b0}}, 1'b1};
        w_data_d = r_seen ? DATA_W'(w_sum >> 1) : i_data;
    end

    // A masked-off channel forgets its history so re-enabling starts raw.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seen <= 1'b0;
        end else if (!i_mask) begin
            r_seen <= 1'b0;
        end else if (i_wr) begin
            r_seen <= 1'b1;
        end
    end
`else
    always_comb begin
        w_data_d = i_data;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= i_wr;
            if (i_wr) begin
                r_data <= w_data_d;
            end
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;

endmodule

// File: rtl/lv_adc_rdout.sv
// Round-robin ADC readout scheduler over the LV-HV request/ack link.
// Optional LV_ADC_AVG_EN enables per-channel averaging in lv_adc_ch_reg.
module lv_adc_rdout
    import lv_adc_pkg::*;
#(
    parameter  int unsigned CH_NUM      = 2,
    parameter  int unsigned DATA_W      = 8,
    parameter  int unsigned TIMEOUT_CYC = 255,
    parameter  int unsigned GAP_CYC     = 16,
    localparam int unsigned CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_adc_en,
    input  logic [CH_NUM-1:0]        i_ch_mask,
    output logic                     o_req,
    output logic [CH_W-1:0]          o_req_ch,
    input  logic                     i_ack,
    input  logic [DATA_W-1:0]        i_ack_data,
    input  logic                     i_ack_err,
    output logic [CH_NUM*DATA_W-1:0] o_adc_data,
    output logic [CH_NUM-1:0]        o_adc_vld,
    output logic [CH_NUM-1:0]        o_adc_en,
    output logic                     o_err_timeout,
    output logic                     o_err_link,
    output logic                     o_busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    lv_adc_st_e       r_state, w_state_d;
    logic [CH_W-1:0]  r_req_ch, w_req_ch_d;
    logic [CH_W-1:0]  r_ptr, w_ptr_d;
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_d;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_d;
    logic             r_err_tmo, w_err_tmo_d;
    logic             r_err_link, w_err_link_d;
    logic [CH_NUM-1:0] r_adc_en;
    logic [CH_NUM-1:0] w_wr;
    logic [15:0]      w_mask16;
    logic             w_wr_ok;
    logic             w_tmo_last;
    logic             w_gap_last;

    assign w_tmo_last = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign w_gap_last = (r_gap_cnt == GAP_W'(GAP_CYC - 1));

    always_comb begin
        w_mask16               = '0;
        w_mask16[CH_NUM-1:0]   = i_ch_mask;
    end

    always_comb begin
        w_state_d    = r_state;
        w_req_ch_d   = r_req_ch;
        w_ptr_d      = r_ptr;
        w_tmo_cnt_d  = r_tmo_cnt;
        w_gap_cnt_d  = r_gap_cnt;
        w_err_tmo_d  = 1'b0;
        w_err_link_d = 1'b0;
        w_wr_ok      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_adc_en && (|i_ch_mask)) begin
                    w_req_ch_d = CH_W'(rr_next(w_mask16, 32'(r_ptr), CH_NUM));
                    w_state_d  = REQ;
                end
            end
            REQ: begin
                w_tmo_cnt_d = '0;
                w_state_d   = i_adc_en ? WAIT : IDLE;
            end
            WAIT: begin
                // Disable aborts silently; pointer and data stay untouched.
                if (!i_adc_en) begin
                    w_state_d = IDLE;
                end else if (i_ack || w_tmo_last) begin
                    w_ptr_d      = r_req_ch;
                    w_err_link_d = i_ack && i_ack_err;
                    w_err_tmo_d  = !i_ack;
                    w_wr_ok      = i_ack && !i_ack_err;
                    w_gap_cnt_d  = '0;
                    w_state_d    = (GAP_CYC == 0) ? IDLE : GAP;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt + TMO_W'(1);
                end
            end
            GAP: begin
                if (w_gap_last) begin
                    w_state_d = IDLE;
                end else begin
                    w_gap_cnt_d = r_gap_cnt + GAP_W'(1);
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_req_ch   <= '0;
            r_ptr      <= CH_W'(CH_NUM - 1);
            r_tmo_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_err_tmo  <= 1'b0;
            r_err_link <= 1'b0;
            r_adc_en   <= '0;
        end else begin
            r_state    <= w_state_d;
            r_req_ch   <= w_req_ch_d;
            r_ptr      <= w_ptr_d;
            r_tmo_cnt  <= w_tmo_cnt_d;
            r_gap_cnt  <= w_gap_cnt_d;
            r_err_tmo  <= w_err_tmo_d;
            r_err_link <= w_err_link_d;
            r_adc_en   <= i_ch_mask & {CH_NUM{i_adc_en}};
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        assign w_wr[k] = w_wr_ok && (r_req_ch == CH_W'(k));

        lv_adc_ch_reg #(
            .DATA_W (DATA_W)
        ) u_ch_reg (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_wr    (w_wr[k]),
            .i_data  (i_ack_data),
`ifdef LV_ADC_AVG_EN
            .i_mask  (i_ch_mask[k]),
`endif
            .o_data  (o_adc_data[k*DATA_W +: DATA_W]),
            .o_vld   (o_adc_vld[k])
        );
    end

    assign o_req         = (r_state == REQ) || (r_state == WAIT);
    assign o_req_ch      = r_req_ch;
    assign o_busy        = (r_state != IDLE);
    assign o_adc_en      = r_adc_en;
    assign o_err_timeout = r_err_tmo;
    assign o_err_link    = r_err_link;

endmodule
